// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button synchronize/debounce, RUN/PAUSE/LAP/IDLE state machine,
// one-second prescaler tick, registered counter clear and lap freeze for the display.
module stopwatch_ctrl #(
    parameter int DIV       = 100_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_btn_start,
    input  logic        i_btn_lap,
    input  logic        i_btn_clr,
    input  logic [15:0] i_cntr_in,
    output logic        o_time_en,
    output logic        o_cnt_clr,
    output logic [15:0] o_disp,
    output logic        o_running,
    output logic        o_lap_frozen,
    output logic        o_overflow
);

    localparam int PW  = $clog2(DIV);
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_t;

    // bit 0 start, bit 1 lap, bit 2 clr
    logic [2:0] w_btn_raw;
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] w_db;
    logic [2:0] r_db_d;
    logic [2:0] w_ev;

    assign w_btn_raw = {i_btn_clr, i_btn_lap, i_btn_start};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db_d  <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_db_d  <= w_db;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_db
        logic           r_level;
        logic [DBW-1:0] r_stab;

        // Level flips only after DB_CYCLES consecutive samples disagreeing with it.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_level <= 1'b0;
                r_stab  <= '0;
            end else if (r_sync2[g] != r_level) begin
                if (r_stab == DB_LAST) begin
                    r_level <= r_sync2[g];
                    r_stab  <= '0;
                end else begin
                    r_stab <= r_stab + DBW'(1);
                end
            end else begin
                r_stab <= '0;
            end
        end

        assign w_db[g] = r_level;
    end

    assign w_ev = w_db & ~r_db_d;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_clr_acc;
    logic          w_lap_cap;
    logic          w_start_run;
    logic          w_cnt_en;
    logic          w_tick;
    logic [PW-1:0] r_presc;
    logic [15:0]   r_lap;
    logic          r_cnt_clr;
    logic          r_overflow;

    // Highest-priority event that the current state acts on wins; the rest are dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_clr_acc   = 1'b0;
        w_lap_cap   = 1'b0;
        w_start_run = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_ev[2]) begin
                    w_clr_acc = 1'b1;
                end else if (w_ev[0]) begin
                    w_state_nxt = S_RUN;
                    w_start_run = 1'b1;
                end
            end
            S_RUN: begin
                if (w_ev[0]) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_ev[1]) begin
                    w_state_nxt = S_LAP;
                    w_lap_cap   = 1'b1;
                end
            end
            S_LAP: begin
                if (w_ev[0]) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_ev[1]) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_PAUSE: begin
                if (w_ev[2]) begin
                    w_state_nxt = S_IDLE;
                    w_clr_acc   = 1'b1;
                end else if (w_ev[0]) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    assign w_cnt_en = (r_state == S_RUN) || (r_state == S_LAP);
    assign w_tick   = w_cnt_en && (r_presc == PRESC_LAST);

    // Prescaler holds in PAUSE so a resume keeps the partial second.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_clr_acc || w_start_run) begin
            r_presc <= '0;
        end else if (w_cnt_en) begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lap      <= 16'h0000;
            r_cnt_clr  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_cnt_clr <= w_clr_acc;
            if (w_lap_cap)
                r_lap <= i_cntr_in;
            if (w_clr_acc)
                r_overflow <= 1'b0;
            else if (w_tick && (i_cntr_in == 16'h5959))
                r_overflow <= 1'b1;
        end
    end

    assign o_time_en    = w_tick;
    assign o_cnt_clr    = r_cnt_clr;
    assign o_running    = w_cnt_en;
    assign o_lap_frozen = (r_state == S_LAP);
    assign o_overflow   = r_overflow;
    assign o_disp       = (r_state == S_LAP) ? r_lap : i_cntr_in;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control block for the MM:SS BCD stopwatch counter. It debounces the three front-panel buttons (start/stop, lap, clear) and runs the stopwatch state machine. It generates the 1-cycle `time_en` tick from `clk` through a prescaler and issues the counter clear pulse. It also freezes a lap value for the display path and sits between the board buttons and the counter and display multiplexer.

## Interface
- `DIV`, default 100_000_000: prescaler period in `clk` cycles per `time_en` tick (1 s at 100 MHz); legal range ≥ 2.
- `DB_CYCLES`, default 1_000_000: consecutive stable synchronized samples needed to change a debounced level (10 ms); legal range ≥ 1.
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high; clock `clk`.
- `btn_start` input 1: raw start/stop button, asynchronous, active-high.
- `btn_lap` input 1: raw lap button, asynchronous, active-high.
- `btn_clr` input 1: raw clear button, asynchronous, active-high.
- `cntr_in` input 16: live BCD count {M10, M1, S10, S1} from the counter.
- `time_en` output 1: count-enable tick to the counter, 1 cycle wide.
- `cnt_clr` output 1: registered 1-cycle clear pulse to the counter reset.
- `disp` output 16: value to display; live `cntr_in`, or the frozen lap value.
- `running` output 1: high in RUN or LAP.
- `lap_frozen` output 1: high in LAP.
- `overflow` output 1: sticky; set when the counter wraps from 59:59.

## Operation
- **Button conditioning**
  - Each button passes through a 2-flop synchronizer.
  - The debounced level toggles only after `DB_CYCLES` consecutive synchronized samples that differ from the current level; any mismatch restarts the stability count.
  - A press event is a 1-cycle pulse on the debounced level's rising edge. Releases generate no event.
- **States:** IDLE (stopped, zeroed), RUN, PAUSE, LAP (counting, display frozen).
- **Event priority per cycle:** clr > start > lap. At most one event is acted on per cycle; lower-priority events in the same cycle are discarded.
- **Transitions**
  - IDLE: start → RUN. clr → IDLE with `cnt_clr` pulse. lap is ignored.
  - RUN: start → PAUSE. lap → LAP and captures `cntr_in` into the lap register. clr is ignored.
  - LAP: lap → RUN (display goes live). start → PAUSE (display goes live). clr is ignored.
  - PAUSE: start → RUN. clr → IDLE with `cnt_clr` pulse and `overflow` cleared. lap is ignored.
- **Prescaler:** width is `$clog2(DIV)`.
  - It counts 0..DIV-1 only in RUN/LAP.
  - `time_en` = 1 for exactly the cycle in which the prescaler equals DIV-1 while in RUN/LAP. The prescaler then wraps to 0.
  - PAUSE holds the prescaler value, so a resume keeps the partial second.
  - The IDLE→RUN transition and any `cnt_clr` zero the prescaler.
- **`disp`:** the lap register in LAP, otherwise `cntr_in` (combinational mux).
- **`overflow`:** set on the cycle `time_en` = 1 while `cntr_in` == 16'h5959. It stays set until clr is accepted or reset.
- **Counter clear timing:** `cnt_clr` is driven from a flop, so it is glitch-free and safe to OR into the counter's asynchronous reset.

## Timing
- **Reset values:**
  - state IDLE
  - `time_en` 0, `cnt_clr` 0
  - `running` 0, `lap_frozen` 0, `overflow` 0
  - prescaler 0, lap register 16'h0000
  - debounced levels 0, stability counters 0
  - `disp` = `cntr_in`
- **Button latency:** raw button rises before edge 0.
  - Synchronized level is high after edge 1.
  - Debounced level is high after edge 1+DB_CYCLES.
  - Event pulse is high in the cycle after edge 1+DB_CYCLES.
  - State and outputs change at edge 2+DB_CYCLES.
- **`cnt_clr` timing:** high for the single cycle following the edge that accepts clr.
- **First tick:** after entering RUN from IDLE, the first `time_en` is high DIV cycles after the transition edge. Subsequent ticks follow every DIV cycles.
- **Reset mid-operation:** everything returns to reset values immediately. A button held through reset release produces an event once it has been stable-high for the debounce window, measured from reset release.
- **No auto-repeat:** holding a button produces one event only.

## Test plan
Run all scenarios with `DIV`=4 and `DB_CYCLES`=3.
- **Reset:** apply reset → all outputs at reset values; `disp` follows `cntr_in`=16'h1234.
- **Start/tick/pause:** press start (held 10 cycles) → `running`=1 at edge 5 after press. `time_en` pulses every 4 cycles, first pulse 4 cycles after entry. Press start again → `time_en` stops. Press start again → first pulse arrives after the remaining prescaler count.
- **Lap:** in RUN, drive `cntr_in`=16'h0123 and press lap → `disp`=16'h0123 while `cntr_in` advances and `lap_frozen`=1. Press lap again → `disp` is live and `lap_frozen`=0.
- **Clear and priority:** in RUN, press clr → no `cnt_clr`. Press start and clr on the same cycle while in PAUSE → IDLE and one `cnt_clr` pulse; start is discarded.
- **Overflow:** in RUN with `cntr_in`=16'h5959 at a tick → `overflow`=1 and it stays high. Pause, then clr → `overflow`=0.
- **Bounce:** toggle `btn_start` 1-0-1 at 1-cycle intervals, then hold → exactly one start event, taken after 3 stable cycles.
